// File: rtl/bist_pkg.sv
// bist_pkg.sv
// Shared state encoding and default sizing for the link BIST sequencer.
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_LAUNCH,
    ST_SETTLE,
    ST_WAIT,
    ST_RECORD,
    ST_DONE
  } bist_state_e;

  localparam int DEF_NUM_LINKS      = 4;
  localparam int DEF_TIMEOUT_CYCLES = 2048;
  localparam int DEF_MAX_RETRIES    = 2;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bist_timeout_counter.sv
// bist_timeout_counter.sv
// Per-attempt wait counter with synchronous clear and terminal-count flag.
module bist_timeout_counter #(
  parameter int WIDTH    = 11,
  parameter int TERMINAL = 2047
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Clear wins over enable so a relaunch always starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/bist_ctrl.sv
// bist_ctrl.sv
// Sequences BIST over masked links with per-link retry and timeout.
module bist_ctrl
  import bist_pkg::*;
#(
  parameter int NUM_LINKS      = DEF_NUM_LINKS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_LINKS-1:0] link_mask,
  input  logic [NUM_LINKS-1:0] rx_ready,
  input  logic [NUM_LINKS-1:0] rx_failed,
  output logic [NUM_LINKS-1:0] bist_reset,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_LINKS-1:0] pass_mask,
  output logic [NUM_LINKS-1:0] timeout_mask
);

  localparam int IDX_W = $clog2(NUM_LINKS + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam int RTY_W = cnt_w(MAX_RETRIES + 1);

  bist_state_e state_q, state_d;
  logic [NUM_LINKS-1:0] mask_q, mask_d;
  logic [NUM_LINKS-1:0] pass_q, pass_d;
  logic [NUM_LINKS-1:0] tmo_q, tmo_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic to_q, to_d;
  logic fail_q, fail_d;

  logic [NUM_LINKS-1:0] sel;
  logic cnt_clr;
  logic cnt_en;
  logic cnt_tc;

  // One-hot of the current link; all zero once the index runs past the end.
  assign sel = NUM_LINKS'(1) << idx_q;

  bist_timeout_counter #(
    .WIDTH   (TMO_W),
    .TERMINAL(TIMEOUT_CYCLES - 1)
  ) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clr),
    .enable(cnt_en),
    .tc    (cnt_tc)
  );

  // Next-state and datapath updates for the sweep.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    pass_d  = pass_q;
    tmo_d   = tmo_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    to_d    = to_q;
    fail_d  = fail_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d  = link_mask;
          pass_d  = '0;
          tmo_d   = '0;
          idx_d   = '0;
          retry_d = '0;
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (idx_q >= IDX_W'(NUM_LINKS)) begin
          state_d = ST_DONE;
        end else if ((mask_q & sel) == '0) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        cnt_clr = 1'b1;
        state_d = ST_SETTLE;
      end
      // Ready may still be high from the previous run here.
      ST_SETTLE: state_d = ST_WAIT;
      ST_WAIT: begin
        cnt_en = 1'b1;
        if ((rx_ready & sel) != '0) begin
          to_d    = 1'b0;
          fail_d  = (rx_failed & sel) != '0;
          state_d = ST_RECORD;
        end else if (cnt_tc) begin
          to_d    = 1'b1;
          fail_d  = 1'b0;
          state_d = ST_RECORD;
        end
      end
      ST_RECORD: begin
        if (!to_q && !fail_q) begin
          pass_d  = pass_q | sel;
          retry_d = '0;
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_SELECT;
        end else if (retry_q < RTY_W'(MAX_RETRIES)) begin
          retry_d = retry_q + RTY_W'(1);
          state_d = ST_LAUNCH;
        end else begin
          if (to_q) begin
            tmo_d = tmo_q | sel;
          end
          retry_d = '0;
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_SELECT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      pass_q  <= '0;
      tmo_q   <= '0;
      idx_q   <= '0;
      retry_q <= '0;
      to_q    <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
      tmo_q   <= tmo_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      to_q    <= to_d;
      fail_q  <= fail_d;
    end
  end

  assign bist_reset   = (state_q == ST_LAUNCH) ? sel : '0;
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done         = (state_q == ST_DONE);
  assign pass_mask    = pass_q;
  assign timeout_mask = tmo_q;

endmodule
